// File: rtl/regfile_ops_pkg.sv
// -----------------------------------------------------------------------------
// regfile_ops_pkg
// Shared definitions for the register-file op bus: opcode constants, request
// kind encodings, default widths and the sequencer FSM state type.
// Imported by regfile_sequencer and by the register file itself.
// -----------------------------------------------------------------------------
package regfile_ops_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned OP_WIDTH       = 16;

    localparam logic [OP_WIDTH-1:0] OP_NOP     = 16'h0000;
    localparam logic [OP_WIDTH-1:0] OP_WRITE   = 16'h2100;
    localparam logic [OP_WIDTH-1:0] OP_READ    = 16'h2200;
    localparam logic [3:0]          OP_ALU_NIB = 4'b0001;

    typedef enum logic [1:0] {
        KIND_WRITE   = 2'b00,
        KIND_READ    = 2'b01,
        KIND_ALU     = 2'b10,
        KIND_ILLEGAL = 2'b11
    } req_kind_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        VERIFY,
        RESP
    } seq_state_e;

    // ALU opcode: fixed top nibble, function nibble, zero low byte.
    function automatic logic [OP_WIDTH-1:0] alu_op(input logic [3:0] fn);
        return {OP_ALU_NIB, fn, 8'h00};
    endfunction

endpackage

// File: rtl/regfile_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_sequencer
// Initiator side of the register-file op interface. Accepts one WRITE, READ or
// ALU command at a time on a valid/ready request channel, drives the op bus
// for exactly one cycle, captures the read result and returns a response on a
// valid/ready response channel. All outputs are registered.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   req_valid/req_ready        request handshake
//   req_kind/req_fn            command kind (00 WR, 01 RD, 10 ALU, 11 illegal)
//                              and ALU function nibble
//   req_addr_1/2/3, req_data   command operands
//   op, addr_1/2/3, write_data op bus to the register file
//   read_data_reg              combinational single-read result from the file
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_err          response payload
//
// Build option: REGSEQ_READBACK_EN adds a VERIFY read after every WRITE and
// returns the read-back value, flagging rsp_err on mismatch.
// -----------------------------------------------------------------------------
module regfile_sequencer
    import regfile_ops_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_kind,
    input  logic [3:0]            req_fn,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_2,
    input  logic [ADDR_WIDTH-1:0] req_addr_3,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic [OP_WIDTH-1:0]   op,
    output logic [ADDR_WIDTH-1:0] addr_1,
    output logic [ADDR_WIDTH-1:0] addr_2,
    output logic [ADDR_WIDTH-1:0] addr_3,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data_reg,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    seq_state_e            state_q, state_d;
    req_kind_e             kind_q, kind_d;
    logic                  req_ready_q, req_ready_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_1_q, addr_1_d;
    logic [ADDR_WIDTH-1:0] addr_2_q, addr_2_d;
    logic [ADDR_WIDTH-1:0] addr_3_q, addr_3_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
`ifdef REGSEQ_READBACK_EN
    logic [DATA_WIDTH-1:0] data_q, data_d;
`endif

    logic accept;
    assign accept = req_valid && req_ready_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            kind_q       <= KIND_WRITE;
            req_ready_q  <= 1'b0;
            op_q         <= OP_NOP;
            addr_1_q     <= '0;
            addr_2_q     <= '0;
            addr_3_q     <= '0;
            write_data_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
`ifdef REGSEQ_READBACK_EN
            data_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            req_ready_q  <= req_ready_d;
            op_q         <= op_d;
            addr_1_q     <= addr_1_d;
            addr_2_q     <= addr_2_d;
            addr_3_q     <= addr_3_d;
            write_data_q <= write_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
`ifdef REGSEQ_READBACK_EN
            data_q       <= data_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept) state_d = ISSUE;
            ISSUE: begin
                state_d = RESP;
`ifdef REGSEQ_READBACK_EN
                if (kind_q == KIND_WRITE) state_d = VERIFY;
`endif
            end
            VERIFY: state_d = RESP;
            RESP:   if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered-output next values
    always_comb begin
        kind_d       = kind_q;
        req_ready_d  = req_ready_q;
        op_d         = op_q;
        addr_1_d     = addr_1_q;
        addr_2_d     = addr_2_q;
        addr_3_d     = addr_3_q;
        write_data_d = write_data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
`ifdef REGSEQ_READBACK_EN
        data_d       = data_q;
`endif
        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d  = 1'b0;
                    kind_d       = req_kind_e'(req_kind);
`ifdef REGSEQ_READBACK_EN
                    data_d       = req_data;
`endif
                    op_d         = OP_NOP;
                    addr_1_d     = '0;
                    addr_2_d     = '0;
                    addr_3_d     = req_addr_3;
                    write_data_d = '0;
                    case (req_kind_e'(req_kind))
                        KIND_WRITE: begin
                            op_d         = OP_WRITE;
                            write_data_d = req_data;
                        end
                        KIND_READ:  op_d = OP_READ;
                        KIND_ALU: begin
                            op_d     = alu_op(req_fn);
                            addr_1_d = req_addr_1;
                            addr_2_d = req_addr_2;
                        end
                        // Illegal kind: op bus stays idle, no file side effect.
                        default:    addr_3_d = '0;
                    endcase
                end
            end
            ISSUE: begin
                op_d         = OP_NOP;
                addr_1_d     = '0;
                addr_2_d     = '0;
                addr_3_d     = '0;
                write_data_d = '0;
                rsp_valid_d  = 1'b1;
                rsp_data_d   = '0;
                rsp_err_d    = 1'b0;
                case (kind_q)
                    KIND_READ:    rsp_data_d = read_data_reg;
                    KIND_ILLEGAL: rsp_err_d  = 1'b1;
                    default:      ;
                endcase
`ifdef REGSEQ_READBACK_EN
                // WRITE chains straight into a read of the same register.
                if (kind_q == KIND_WRITE) begin
                    op_d        = OP_READ;
                    addr_3_d    = addr_3_q;
                    rsp_valid_d = 1'b0;
                end
`endif
            end
            VERIFY: begin
                op_d        = OP_NOP;
                addr_3_d    = '0;
                rsp_valid_d = 1'b1;
`ifdef REGSEQ_READBACK_EN
                rsp_data_d  = read_data_reg;
                rsp_err_d   = (read_data_reg != data_q);
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req_ready  = req_ready_q;
    assign op         = op_q;
    assign addr_1     = addr_1_q;
    assign addr_2     = addr_2_q;
    assign addr_3     = addr_3_q;
    assign write_data = write_data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_sequencer
// Bench for regfile_sequencer with a behavioural 16-entry register file
// (including an ALU add on writeback) attached to the op bus.
// Honours REGSEQ_READBACK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_regfile_sequencer;
    import regfile_ops_pkg::*;

`ifdef REGSEQ_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [3:0]  req_fn;
    logic [3:0]  req_addr_1, req_addr_2, req_addr_3;
    logic [15:0] req_data;
    logic [15:0] op;
    logic [3:0]  addr_1, addr_2, addr_3;
    logic [15:0] write_data;
    logic [15:0] read_data_reg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    regfile_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_fn(req_fn),
        .req_addr_1(req_addr_1), .req_addr_2(req_addr_2), .req_addr_3(req_addr_3),
        .req_data(req_data),
        .op(op), .addr_1(addr_1), .addr_2(addr_2), .addr_3(addr_3),
        .write_data(write_data), .read_data_reg(read_data_reg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file; ALU result is the sum of the two sources.
    logic [15:0] regs [16];
    logic        force_zero;
    assign read_data_reg = force_zero ? 16'h0000 : regs[addr_3];

    always @(posedge clk) begin
        if (op == 16'h2100)
            regs[addr_3] <= write_data;
        else if (op[15:12] == 4'h1 && op[7:0] == 8'h00)
            regs[addr_3] <= regs[addr_1] + regs[addr_2];
    end

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  fn;
        logic [3:0]  a1, a2, a3;
        logic [15:0] data;
        int          hold;
        bit          force0;
        logic [15:0] exp_data;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        bit          err;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] kind, input logic [3:0] fn,
                                input logic [3:0] a1, input logic [3:0] a2,
                                input logic [3:0] a3, input logic [15:0] data,
                                input int hold, input bit force0,
                                input logic [15:0] exp_data, input bit exp_err);
        vec_t v;
        v.kind = kind; v.fn = fn; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.data = data; v.hold = hold; v.force0 = force0;
        v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic logic [15:0] exp_op(input vec_t v);
        case (v.kind)
            2'b00:   return 16'h2100;
            2'b01:   return 16'h2200;
            2'b10:   return {4'b0001, v.fn, 8'h00};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_cmd(input vec_t v);
        int   n;
        bit   vfy;
        rsp_t r;
        vfy = RB && (v.kind == 2'b00);
        wait_ready();
        req_valid  = 1'b1;
        req_kind   = v.kind;
        req_fn     = v.fn;
        req_addr_1 = v.a1;
        req_addr_2 = v.a2;
        req_addr_3 = v.a3;
        req_data   = v.data;
        rsp_ready  = (v.hold == 0);
        r.data = v.exp_data;
        r.err  = v.exp_err;
        sb.push_back(r);
        step();
        req_valid = 1'b0;
        // cycle k+1: op bus carries the command
        chk("issue_op", {16'd0, op}, {16'd0, exp_op(v)});
        chk("issue_addr_1", {28'd0, addr_1}, {28'd0, (v.kind == 2'b10) ? v.a1 : 4'h0});
        chk("issue_addr_2", {28'd0, addr_2}, {28'd0, (v.kind == 2'b10) ? v.a2 : 4'h0});
        if (v.kind != 2'b11)
            chk("issue_addr_3", {28'd0, addr_3}, {28'd0, v.a3});
        chk("issue_wdata", {16'd0, write_data}, {16'd0, (v.kind == 2'b00) ? v.data : 16'h0});
        chk("issue_req_ready", {31'd0, req_ready}, 32'd0);
        chk("issue_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        if (vfy) begin
            chk("verify_op", {16'd0, op}, {16'd0, 16'h2200});
            chk("verify_addr_3", {28'd0, addr_3}, {28'd0, v.a3});
            chk("verify_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            force_zero = v.force0;
            step();
            force_zero = 1'b0;
        end
        chk("rsp_latency", {31'd0, rsp_valid}, 32'd1);
        chk("resp_op_nop", {16'd0, op}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
            void'(sb.pop_front());
            return;
        end
        for (int i = 0; i < v.hold; i++) begin
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_data", {16'd0, rsp_data}, {16'd0, v.exp_data});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_op", {16'd0, op}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        r = sb.pop_front();
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, r.data});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
        step();
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_kind   = 2'b00;
        req_fn     = 4'h0;
        req_addr_1 = 4'h0;
        req_addr_2 = 4'h0;
        req_addr_3 = 4'h0;
        req_data   = 16'h0;
        rsp_ready  = 1'b0;
        force_zero = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0;

        // Table: kind fn a1 a2 a3 data hold force0 exp_data exp_err
        vecs.push_back(mk(2'b00, 4'h0, 4'h0, 4'h0, 4'h5, 16'hBEEF, 0, 1'b0, RB ? 16'hBEEF : 16'h0, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 4'h0, 4'h0, 4'h5, 16'h0000, 0, 1'b0, 16'hBEEF, 1'b0));
        vecs.push_back(mk(2'b00, 4'h0, 4'h0, 4'h0, 4'h1, 16'h0011, 0, 1'b0, RB ? 16'h0011 : 16'h0, 1'b0));
        vecs.push_back(mk(2'b00, 4'h0, 4'h0, 4'h0, 4'h2, 16'h0022, 0, 1'b0, RB ? 16'h0022 : 16'h0, 1'b0));
        vecs.push_back(mk(2'b10, 4'h3, 4'h1, 4'h2, 4'h7, 16'hFFFF, 0, 1'b0, 16'h0, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 4'h0, 4'h0, 4'h7, 16'h0000, 0, 1'b0, 16'h0033, 1'b0));
        vecs.push_back(mk(2'b11, 4'h0, 4'h0, 4'h0, 4'h5, 16'h1111, 0, 1'b0, 16'h0, 1'b1));
        vecs.push_back(mk(2'b01, 4'h0, 4'h0, 4'h0, 4'h5, 16'h0000, 0, 1'b0, 16'hBEEF, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 4'h0, 4'h0, 4'h5, 16'h0000, 4, 1'b0, 16'hBEEF, 1'b0));
        vecs.push_back(mk(2'b00, 4'h0, 4'h0, 4'h0, 4'h3, 16'h1234, 0, 1'b0, RB ? 16'h1234 : 16'h0, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 4'h0, 4'h0, 4'h3, 16'h0000, 0, 1'b0, 16'h1234, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 4'h0, 4'h0, 4'hF, 16'h0000, 0, 1'b0, 16'h0000, 1'b0));
`ifdef REGSEQ_READBACK_EN
        vecs.push_back(mk(2'b00, 4'h0, 4'h0, 4'h0, 4'h4, 16'h5555, 0, 1'b1, 16'h0000, 1'b1));
        vecs.push_back(mk(2'b01, 4'h0, 4'h0, 4'h0, 4'h4, 16'h0000, 0, 1'b0, 16'h5555, 1'b0));
`endif

        // Reset state
        step();
        step();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_op", {16'd0, op}, 32'd0);
        chk("rst_addr_3", {28'd0, addr_3}, 32'd0);
        chk("rst_write_data", {16'd0, write_data}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;
        step();
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        foreach (vecs[i]) run_cmd(vecs[i]);

        // Reset during ISSUE of WRITE to reg 9: command dropped, no write.
        wait_ready();
        req_valid  = 1'b1;
        req_kind   = 2'b00;
        req_addr_3 = 4'h9;
        req_data   = 16'hAAAA;
        step();
        req_valid = 1'b0;
        chk("midrst_issue_op", {16'd0, op}, 32'h2100);
        reset = 1'b1;
        #1;
        chk("midrst_op", {16'd0, op}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        run_cmd(mk(2'b01, 4'h0, 4'h0, 4'h0, 4'h9, 16'h0000, 0, 1'b0, 16'h0000, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
